// File: rtl/ex_pkg.sv
// Shared constants and enumerations for the EX-stage multiply/divide unit.
package ex_pkg;

    localparam logic [6:0] OP_REG       = 7'b0110011;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Radix-2 iteration registers for the multiply/divide unit: shift-add multiply and
// restoring divide on unsigned magnitudes. {hi, lo} holds product or {remainder, quotient}.
module ex_muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_fits;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_fits  = div_shift >= {1'b0, b_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        if (load) begin
            hi_d = '0;
            lo_d = a_in;
            b_d  = b_in;
        end else if (step) begin
            if (is_div) begin
                // Partial remainder always fits XLEN bits once the trial subtract succeeds.
                hi_d = div_fits ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], div_fits};
            end else begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execution unit: handshake FSM, fast-path special cases and
// sign correction around an iterative unsigned datapath.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
    input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
    input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
    input  logic [XLEN-1:0]            rs1_in,
    input  logic [XLEN-1:0]            rs2_in,
    input  logic [4:0]                 rd_in,
    input  logic                       flush_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [XLEN-1:0]            result_out,
    output logic [4:0]                 rd_out,
    output logic                       busy_out
);

    localparam int CNT_W = 6;

    muldiv_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    muldiv_op_e      func3_q;
    logic [4:0]      rd_q;
    logic            a_neg_q, b_neg_q;

    muldiv_op_e      op_in;
    logic            accept, a_neg_in, b_neg_in, div_zero, div_ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res, final_res;
    logic            dp_load, dp_step;
    logic [XLEN-1:0] dp_hi, dp_lo;
    logic [2*XLEN-1:0] prod, prod_s;

    assign op_in  = muldiv_op_e'(alu_func3_in);
    assign accept = valid_in && (state_q == StIdle) && !flush_in &&
                    (alu_op_in == ALU_OP_WIDTH'(OP_REG)) &&
                    (alu_func7_in == ALU_FUNC7_WIDTH'(FUNC7_MULDIV));

    always_comb begin
        a_neg_in = (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && rs1_in[XLEN-1];
        b_neg_in = (op_in inside {OpMulh, OpDiv, OpRem}) && rs2_in[XLEN-1];
        a_mag    = a_neg_in ? -rs1_in : rs1_in;
        b_mag    = b_neg_in ? -rs2_in : rs2_in;
        div_zero = alu_func3_in[2] && (rs2_in == '0);
        div_ovf  = (op_in inside {OpDiv, OpRem}) && (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (rs2_in == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) fast_res = (op_in inside {OpDiv, OpDivu}) ? '1 : rs1_in;
        else          fast_res = (op_in == OpDiv) ? rs1_in : '0;
    end

    // Sign correction on the magnitudes left in the datapath.
    always_comb begin
        prod   = {dp_hi, dp_lo};
        prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
        unique case (func3_q)
            OpMul:                    final_res = prod_s[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: final_res = prod_s[2*XLEN-1:XLEN];
            OpDiv:                    final_res = (a_neg_q ^ b_neg_q) ? -dp_lo : dp_lo;
            OpDivu:                   final_res = dp_lo;
            OpRem:                    final_res = a_neg_q ? -dp_hi : dp_hi;
            OpRemu:                   final_res = dp_hi;
            default:                  final_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dp_load = 1'b1;
                    cnt_d   = '0;
                    if (fast) begin
                        state_d  = StDone;
                        result_d = fast_res;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush_in) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(XLEN)) begin
                    state_d  = StDone;
                    result_d = final_res;
                end else begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (flush_in || ready_in) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            result_q <= '0;
            func3_q  <= OpMul;
            rd_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            if (accept) begin
                func3_q <= op_in;
                rd_q    <= rd_in;
                a_neg_q <= a_neg_in;
                b_neg_q <= b_neg_in;
            end
        end
    end

    ex_muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (dp_load),
        .step   (dp_step),
        .is_div (func3_q[2]),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .hi_out (dp_hi),
        .lo_out (dp_lo)
    );

    assign ready_out  = (state_q == StIdle);
    assign busy_out   = (state_q != StIdle);
    assign valid_out  = (state_q == StDone);
    assign result_out = valid_out ? result_q : '0;
    assign rd_out     = valid_out ? rd_q : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized operations
// checked against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv_unit;

    localparam logic [6:0] OPC_REG  = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] F7_MD    = 7'b0000001;
    localparam int         LAT_NORM = 33;

    logic        clk = 1'b0;
    logic        reset, valid_in, ready_out, flush_in, valid_out, ready_in, busy_out;
    logic [6:0]  alu_op_in, alu_func7_in;
    logic [2:0]  alu_func3_in;
    logic [31:0] rs1_in, rs2_in, result_out;
    logic [4:0]  rd_in, rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .alu_op_in    (alu_op_in),
        .alu_func3_in (alu_func3_in),
        .alu_func7_in (alu_func7_in),
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .rd_in        (rd_in),
        .flush_in     (flush_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .result_out   (result_out),
        .rd_out       (rd_out),
        .busy_out     (busy_out)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: return up[31:0];
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges after the accept edge until valid_out; the fast path is up right after accept.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 0;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return LAT_NORM;
    endfunction

    task automatic idle_inputs();
        valid_in     = 1'b0;
        flush_in     = 1'b0;
        ready_in     = 1'b1;
        alu_op_in    = OPC_REG;
        alu_func7_in = F7_MD;
        alu_func3_in = 3'd0;
        rs1_in       = '0;
        rs2_in       = '0;
        rd_in        = '0;
    endtask

    // Presents one M-extension op for one edge, then scrambles the operand inputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        alu_op_in    = OPC_REG;
        alu_func7_in = F7_MD;
        alu_func3_in = f3;
        rs1_in       = a;
        rs2_in       = b;
        rd_in        = rd;
        valid_in     = 1'b1;
        @(posedge clk);
        #1;
        valid_in     = 1'b0;
        alu_func3_in = 3'($urandom);
        rs1_in       = $urandom;
        rs2_in       = $urandom;
        rd_in        = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_out && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic watch_no_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s no_valid: got valid_out=1 expected none", name);
        end
    endtask

    task automatic test_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        int          exp_lat, lat;
        exp     = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, ready_out);
        end
        issue(f3, a, b, rd);
        wait_valid(lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (result_out !== exp) begin
            errors++;
            $display("FAIL %s result (f3=%0d a=%h b=%h): got %h expected %h",
                     name, f3, a, b, result_out, exp);
        end
        checks++;
        if (rd_out !== rd) begin
            errors++;
            $display("FAIL %s rd: got %0d expected %0d", name, rd_out, rd);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({valid_out, ready_out, busy_out, result_out, rd_out} !== {3'b010, 37'h0}) begin
            errors++;
            $display("FAIL %s release: got v=%b r=%b b=%b res=%h rd=%0d expected 0 1 0 0 0",
                     name, valid_out, ready_out, busy_out, result_out, rd_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({valid_out, ready_out, busy_out, result_out, rd_out} !== {3'b010, 37'h0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%b b=%b res=%h rd=%0d expected 0 1 0 0 0",
                     valid_out, ready_out, busy_out, result_out, rd_out);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        test_op("mul_neg",      3'd0, 32'd7,         32'hFFFF_FFFD, 5'd9);
        test_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        test_op("mulh_m1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        test_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        test_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        test_op("divu_zero",    3'd5, 32'h0000_1234, 32'h0,         5'd5);
        test_op("remu_zero",    3'd7, 32'h0000_1234, 32'h0,         5'd6);
        test_op("rem_neg",      3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7);
        test_op("div_neg",      3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8);
        test_op("mulhsu_neg",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel;
        for (int i = 0; i < 60; i++) begin
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin
                a = 32'($signed($urandom_range(0, 200)) - 100);
                b = 32'($signed($urandom_range(0, 20)) - 10);
            end
            test_op("random", f3, a, b, 5'($urandom));
        end
    endtask

    task automatic test_back_to_back_hold();
        logic [31:0] a, b, exp;
        int          lat;
        a        = $urandom;
        b        = $urandom;
        exp      = ref_result(3'd0, a, b);
        ready_in = 1'b0;
        issue(3'd0, a, b, 5'd17);
        wait_valid(lat);
        checks++;
        if (lat != LAT_NORM) begin
            errors++;
            $display("FAIL hold latency: got %0d expected %0d", lat, LAT_NORM);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({valid_out, busy_out, ready_out, result_out, rd_out} !== {3'b110, exp, 5'd17})
            begin
                errors++;
                $display("FAIL hold cycle%0d: got v=%b b=%b r=%b res=%h rd=%0d expected %h/17",
                         i, valid_out, busy_out, ready_out, result_out, rd_out, exp);
            end
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready_out, valid_out, busy_out} !== 3'b100) begin
            errors++;
            $display("FAIL hold release: got r=%b v=%b b=%b expected 1 0 0",
                     ready_out, valid_out, busy_out);
        end
        // A new op is accepted straight after the release.
        test_op("after_hold", 3'd5, 32'd100, 32'd7, 5'd18);
    endtask

    task automatic test_flush();
        issue(3'd0, $urandom, $urandom, 5'd11);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        checks++;
        if ({ready_out, busy_out, valid_out} !== 3'b100) begin
            errors++;
            $display("FAIL flush_busy: got r=%b b=%b v=%b expected 1 0 0",
                     ready_out, busy_out, valid_out);
        end
        watch_no_valid("flush_busy");

        ready_in = 1'b0;
        issue(3'd5, 32'd5, 32'd0, 5'd12);
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        ready_in = 1'b1;
        checks++;
        if ({ready_out, valid_out} !== 2'b10) begin
            errors++;
            $display("FAIL flush_done: got r=%b v=%b expected 1 0", ready_out, valid_out);
        end

        // Flush alongside valid_in in IDLE blocks the accept.
        alu_op_in    = OPC_REG;
        alu_func7_in = F7_MD;
        alu_func3_in = 3'd0;
        valid_in     = 1'b1;
        flush_in     = 1'b1;
        @(posedge clk);
        #1;
        valid_in     = 1'b0;
        flush_in     = 1'b0;
        checks++;
        if ({ready_out, busy_out} !== 2'b10) begin
            errors++;
            $display("FAIL flush_idle: got r=%b b=%b expected 1 0", ready_out, busy_out);
        end
        watch_no_valid("flush_idle");
    endtask

    task automatic test_reset_mid_op();
        issue(3'd4, $urandom, 32'd3, 5'd13);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({valid_out, ready_out, busy_out, result_out, rd_out} !== {3'b010, 37'h0}) begin
            errors++;
            $display("FAIL reset_busy: got v=%b r=%b b=%b res=%h rd=%0d expected 0 1 0 0 0",
                     valid_out, ready_out, busy_out, result_out, rd_out);
        end
        watch_no_valid("reset_busy");

        ready_in = 1'b0;
        issue(3'd7, 32'd99, 32'd0, 5'd14);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ready_in = 1'b1;
        checks++;
        if ({valid_out, ready_out, result_out} !== {2'b01, 32'h0}) begin
            errors++;
            $display("FAIL reset_done: got v=%b r=%b res=%h expected 0 1 0",
                     valid_out, ready_out, result_out);
        end
        watch_no_valid("reset_done");
    endtask

    task automatic test_non_m();
        valid_in     = 1'b1;
        alu_op_in    = OPC_IMM;
        alu_func7_in = F7_MD;
        alu_func3_in = 3'd0;
        rs1_in       = 32'd3;
        rs2_in       = 32'd4;
        @(posedge clk);
        #1;
        checks++;
        if ({ready_out, busy_out} !== 2'b10) begin
            errors++;
            $display("FAIL non_m_opcode: got r=%b b=%b expected 1 0", ready_out, busy_out);
        end
        alu_op_in    = OPC_REG;
        alu_func7_in = 7'b0100000;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        checks++;
        if ({ready_out, busy_out} !== 2'b10) begin
            errors++;
            $display("FAIL non_m_func7: got r=%b b=%b expected 1 0", ready_out, busy_out);
        end
        watch_no_valid("non_m");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_back_to_back_hold();
        test_flush();
        test_reset_mid_op();
        test_non_m();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, operand/result width; ALU_OP_WIDTH, default 7, opcode width; ALU_FUNC3_WIDTH, default 3; ALU_FUNC7_WIDTH, default 7.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  operation offered.
- ready_out  out  1  unit can accept.
- alu_op_in  in  ALU_OP_WIDTH  registered EX-stage opcode.
- alu_func3_in  in  ALU_FUNC3_WIDTH  operation select.
- alu_func7_in  in  ALU_FUNC7_WIDTH  M-extension qualifier.
- rs1_in  in  XLEN  operand 1.
- rs2_in  in  XLEN  operand 2.
- rd_in  in  5  destination tag.
- flush_in  in  1  kill the in-flight operation.
- valid_out  out  1  result available.
- ready_in  in  1  downstream accepts the result.
- result_out  out  XLEN  result.
- rd_out  out  5  tag of the result.
- busy_out  out  1  stall request to the pipeline.

Function
REQ-003 SHALL accept an operation only when valid_in && ready_out && !flush_in && alu_op_in==OP_REG && alu_func7_in==FUNC7_MULDIV; any other valid_in SHALL cause no state change.
REQ-004 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE; ready_out SHALL be 1 only in IDLE; busy_out SHALL be 1 in BUSY and DONE.
REQ-005 SHALL decode func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL register rs1, rs2, rd and func3 at the accept edge; later input changes SHALL have no effect.
REQ-007 Normal path: SHALL perform 32 radix-2 iterations in BUSY, one per edge, counted by a 6-bit counter; valid_out SHALL rise exactly 33 edges after the accept edge.
REQ-008 Multiply: SHALL form the 64-bit product of the operand magnitudes and apply sign correction.
- MUL returns the low XLEN bits.
- MULH treats both operands as signed.
- MULHSU treats rs1 as signed and rs2 as unsigned.
- MULHU treats both operands as unsigned.
- MULH, MULHSU and MULHU return the high XLEN bits.
REQ-009 Divide: SHALL use restoring division on magnitudes; the quotient is negative iff the operand signs differ (signed ops); the remainder takes the sign of the dividend.
REQ-010 Fast path: SHALL go IDLE -> DONE in one edge (valid_out 1 edge after accept) for these cases:
- divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
- signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
REQ-011 In DONE, valid_out, result_out and rd_out SHALL be held stable until valid_out && ready_in; the unit SHALL return to IDLE on that edge; there is no accept in that same cycle.
REQ-012 flush_in in BUSY or DONE SHALL force IDLE on the next edge, drop the result, and produce no valid_out; flush_in together with valid_in in IDLE SHALL block the accept.
REQ-013 result_out and rd_out SHALL be 0 whenever valid_out is 0.

Reset
REQ-014 reset SHALL take priority over all inputs; on the next edge: state IDLE, counter 0, internal registers 0, valid_out 0, result_out 0, rd_out 0, busy_out 0, ready_out 1.
REQ-015 reset asserted mid-BUSY or in DONE SHALL discard the operation; no valid_out SHALL follow.

Structure
REQ-016 SHALL take from the shared package ex_pkg:
- constant OP_REG = 7'b0110011.
- constant FUNC7_MULDIV = 7'b0000001.
- the muldiv_op_e func3 enum.
- the muldiv_state_e FSM enum.
REQ-017 SHALL instantiate one sub-module, ex_muldiv_datapath, holding the shift/add/subtract iteration registers; FSM, handshake and sign correction SHALL remain in ex_muldiv_unit.

Verification
REQ-018 MUL, rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB exactly 33 edges after accept; rd_out equals rd_in.
REQ-019 MULHU, rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-020 DIV, rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 one edge after accept; DIVU with rs1=0x1234, rs2=0 -> 0xFFFFFFFF; REMU with the same operands -> 0x1234.
REQ-021 REM, rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-022 ready_in held low 5 cycles in DONE -> result and rd stable, busy_out=1 throughout; ready_in high -> IDLE next edge, ready_out=1.
REQ-023 flush_in at the 10th BUSY cycle -> IDLE next edge, no valid_out; reset mid-BUSY -> all outputs 0, ready_out=1; non-M opcode with valid_in=1 -> no accept, ready_out stays 1.
